// File: rtl/seq_div32.sv
// Iterative radix-2 restoring divider for the ALU DIV/DIVU path.
// One quotient bit per cycle, plus a finalize cycle that applies signs and registers the result.
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] BUSY    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state;
  // Restored remainder is always below D, so only the trial value needs the extra bit.
  logic [WIDTH-1:0]   r;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   d;
  logic [5:0]         cnt;
  logic               qneg;
  logic               rneg;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  logic [WIDTH:0]     s;
  logic [WIDTH:0]     t;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  always_comb begin
    s     = {r, q[WIDTH-1]};
    t     = s - {1'b0, d};
    abs_a = (signed_div_i && a[WIDTH-1]) ? -a : a;
    abs_b = (signed_div_i && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      cnt    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else if (annul_i) begin
      state  <= IDLE;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (b == '0) begin
              state <= DIVZERO;
            end else begin
              q     <= abs_a;
              d     <= abs_b;
              r     <= '0;
              cnt   <= '0;
              qneg  <= signed_div_i & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg  <= signed_div_i & a[WIDTH-1];
              state <= BUSY;
            end
          end
        end
        DIVZERO: begin
          result <= '0;
          ready  <= 1'b1;
          state  <= DONE;
        end
        BUSY: begin
          // cnt reaching WIDTH marks the extra cycle that applies signs.
          if (cnt == 6'(WIDTH)) begin
            result <= {(rneg ? -r : r), (qneg ? -q : q)};
            ready  <= 1'b1;
            state  <= DONE;
          end else begin
            if (!t[WIDTH]) begin
              r <= t[WIDTH-1:0];
              q <= {q[WIDTH-2:0], 1'b1};
            end else begin
              r <= s[WIDTH-1:0];
              q <= {q[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (!start_i) begin
            state  <= IDLE;
            result <= '0;
            ready  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result_o = result;
  assign ready_o  = ready;

endmodule
